cpu_load_sequencer: RTL and testbench



---
 rtl/cpu_loader_pkg.sv | 25 ++
 rtl/cpu_load_sequencer.sv | 129 ++++++++++++
 tb/tb_cpu_load_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_loader_pkg.sv
// rtl/cpu_loader_pkg.sv - state encoding and command-byte layout for the CPU loader (S_CSUM exists only with LOADER_CHECKSUM_EN)
package cpu_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_RUN   = 3'd4
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CSUM  = 3'd5
`endif
    } state_t;

    localparam logic [7:0] CMD_RUN  = 8'hFF;
    localparam logic [7:0] CMD_HALT = 8'hFE;

    localparam int CMD_INSTR_BIT = 7;
    localparam int CMD_RSVD_MSB  = 6;
    localparam int CMD_RSVD_LSB  = 5;
    localparam int CMD_ADDR_MSB  = 4;
    localparam int CMD_ADDR_LSB  = 0;

endpackage

// File: rtl/cpu_load_sequencer.sv
// rtl/cpu_load_sequencer.sv - byte-stream frame parser that loads CPU memory and gates CPU reset (optional LOADER_CHECKSUM_EN)
module cpu_load_sequencer
    import cpu_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              cpu_reset,
    output logic              load,
    output logic [ADDR_W-1:0] load_address,
    output logic [DATA_W-1:0] load_data,
    output logic              is_instruction,
    output logic              busy,
    output logic              error
);

    // Count must hold both any length byte and the 2**ADDR_W meaning of 0.
    localparam int CNT_W = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] data_r;
    logic              instr;
    logic              accept;
    logic              cmd_run, cmd_halt, cmd_bad;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
`endif

    assign cmd_run  = (rx_data == CMD_RUN);
    assign cmd_halt = (rx_data == CMD_HALT);
    assign cmd_bad  = (rx_data[CMD_RSVD_MSB:CMD_RSVD_LSB] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        rx_ready   = (state != S_WRITE);
        accept     = rx_valid && rx_ready;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_run)                    state_next = S_RUN;
                    else if (!cmd_halt && !cmd_bad) state_next = S_LEN;
                end
            end
            S_LEN:  if (accept) state_next = S_DATA;
            S_DATA: if (accept) state_next = S_WRITE;
            S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                state_next = (count == CNT_W'(1)) ? S_CSUM : S_DATA;
`else
                state_next = (count == CNT_W'(1)) ? S_IDLE : S_DATA;
`endif
            end
            S_RUN:  if (accept && cmd_halt) state_next = S_IDLE;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: if (accept) state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr   <= '0;
            count  <= '0;
            data_r <= '0;
            instr  <= 1'b0;
            error  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && !cmd_run && !cmd_halt) begin
                        if (cmd_bad) begin
                            error <= 1'b1;
                        end else begin
                            instr <= rx_data[CMD_INSTR_BIT];
                            addr  <= ADDR_W'(rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB]);
`ifdef LOADER_CHECKSUM_EN
                            sum   <= '0;
`endif
                        end
                    end
                end
                S_LEN: begin
                    if (accept)
                        count <= (rx_data == '0) ? CNT_W'(2 ** ADDR_W) : CNT_W'(rx_data);
                end
                S_DATA: begin
                    if (accept) begin
                        data_r <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                        sum    <= sum + rx_data;
`endif
                    end
                end
                S_WRITE: begin
                    addr  <= addr + ADDR_W'(1);
                    count <= count - CNT_W'(1);
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: if (accept && rx_data != sum) error <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign load           = (state == S_WRITE);
    assign cpu_reset      = (state != S_RUN);
    assign busy           = (state != S_IDLE) && (state != S_RUN);
    assign load_address   = load ? addr   : '0;
    assign load_data      = load ? data_r : '0;
    assign is_instruction = load ? instr  : 1'b0;

endmodule

// File: tb/tb_cpu_load_sequencer.sv
// tb/tb_cpu_load_sequencer.sv - scoreboard bench: frame-level reference model vs. observed load pulses
module tb_cpu_load_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       cpu_reset;
    logic       load;
    logic [4:0] load_address;
    logic [7:0] load_data;
    logic       is_instruction;
    logic       busy;
    logic       error;

    cpu_load_sequencer #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .cpu_reset(cpu_reset), .load(load),
        .load_address(load_address), .load_data(load_data),
        .is_instruction(is_instruction), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        logic       instr;
    } ld_t;

    ld_t        exp_q[$];
    logic [7:0] pl[$];
    logic       exp_error;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && load) begin
            ld_t e;
            checks++;
            if (!cpu_reset) begin
                errors++;
                $display("FAIL load_while_running: load=1 cpu_reset=0");
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load: addr=%0d data=%0h instr=%0b", load_address, load_data, is_instruction);
            end else begin
                e = exp_q.pop_front();
                if (load_address !== e.addr || load_data !== e.data || is_instruction !== e.instr) begin
                    errors++;
                    $display("FAIL load_value: got addr=%0d data=%0h instr=%0b expected addr=%0d data=%0h instr=%0b",
                             load_address, load_data, is_instruction, e.addr, e.data, e.instr);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!rx_ready) begin
            errors++;
            $display("FAIL rx_ready_timeout: byte %0h not accepted", b);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = $urandom();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        exp_error = 1'b0;
    endtask

    // Frame model: payload i lands at (addr + i) mod 32; length 32 is sent as 0.
    task automatic send_frame(input bit instr, input int addr, input int csum_delta);
        int         n = pl.size();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: 5'((addr + i) % 32), data: pl[i], instr: instr});
            s = s + pl[i];
        end
        send_byte({instr, 2'b00, 5'(addr)});
        send_byte((n == 32) ? 8'h00 : 8'(n));
        for (int i = 0; i < n; i++) send_byte(pl[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(s + 8'(csum_delta));
        if (csum_delta != 0) exp_error = 1'b1;
`else
        if (csum_delta != 0 || s == 8'h00) ;
`endif
    endtask

    task automatic finish_frame(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin @(posedge clk); #1; n++; end
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_error"}, error, exp_error);
        chk({name, "_cpu_reset"}, cpu_reset, 1);
    endtask

    task automatic random_payload(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; exp_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_load", load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_rx_ready", rx_ready, 1);

        pl = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(1'b1, 3, 0);
        finish_frame("instr_frame");

        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(1'b0, 30, 0);
        finish_frame("wrap_frame");

        random_payload(32);
        send_frame(1'($urandom()), int'($urandom_range(0, 31)), 0);
        finish_frame("len32_frame");

        send_byte(8'hFF);
        chk("run_cpu_reset", cpu_reset, 0);
        send_byte(8'h55);
        chk("run_junk_cpu_reset", cpu_reset, 0);
        chk("run_junk_error", error, 0);
        chk("run_junk_busy", busy, 0);
        send_byte(8'hFE);
        chk("halt_cpu_reset", cpu_reset, 1);

        send_byte(8'h40);
        exp_error = 1'b1;
        chk("bad_cmd_error", error, 1);
        chk("bad_cmd_busy", busy, 0);
        pl = '{8'h5A, 8'hA5};
        send_frame(1'b1, 10, 0);
        finish_frame("after_bad");
        do_reset();
        chk("reset_clears_error", error, 0);

        send_byte(8'h05);
        send_byte(8'h05);
        exp_q.push_back('{addr: 5'd5, data: 8'h11, instr: 1'b0});
        exp_q.push_back('{addr: 5'd6, data: 8'h22, instr: 1'b0});
        send_byte(8'h11);
        send_byte(8'h22);
        @(posedge clk); #1;
        chk("midframe_writes", exp_q.size(), 0);
        chk("midframe_busy", busy, 1);
        do_reset();
        chk("midreset_cpu_reset", cpu_reset, 1);
        chk("midreset_load", load, 0);
        chk("midreset_busy", busy, 0);
        pl = '{8'h77, 8'h88};
        send_frame(1'b1, 0, 0);
        finish_frame("after_midreset");

`ifdef LOADER_CHECKSUM_EN
        pl = '{8'h10, 8'h20};
        send_frame(1'b0, 0, 0);
        finish_frame("csum_good");
        send_frame(1'b0, 0, 1);
        finish_frame("csum_bad");
        do_reset();
`endif

        for (int it = 0; it < 24; it++) begin
            int r = $urandom_range(0, 4);
            if (r <= 2) begin
                random_payload((r == 2 && it % 6 == 0) ? 32 : int'($urandom_range(1, 6)));
                send_frame(1'($urandom()), int'($urandom_range(0, 31)), 0);
                finish_frame("rand_frame");
            end else if (r == 3) begin
                send_byte(8'hFF);
                repeat ($urandom_range(1, 3)) begin
                    logic [7:0] b = 8'($urandom());
                    if (b == 8'hFE) b = 8'h00;
                    send_byte(b);
                end
                chk("rand_run_cpu_reset", cpu_reset, 0);
                send_byte(8'hFE);
                chk("rand_halt_cpu_reset", cpu_reset, 1);
            end else begin
                logic [7:0] b;
                b = {1'($urandom()), 2'($urandom_range(1, 3)), 5'($urandom())};
                if (b == 8'hFF || b == 8'hFE) b = 8'h20;
                send_byte(b);
                exp_error = 1'b1;
                chk("rand_bad_error", error, 1);
                do_reset();
                chk("rand_reset_error", error, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
